// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default width.
package mdu_pkg;

  localparam int MDU_DATA_W = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One combinational MDU iteration: LSB-first shift-add (multiply) or MSB-first
// restoring subtract (divide) on {accumulator, operand}.
module mdu_step #(
  parameter int DATA_W = 32
) (
  input  logic                  is_div_i,
  input  logic [2*DATA_W-1:0]   acc_i,
  input  logic [DATA_W-1:0]     opnd_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic [2*DATA_W-1:0]   acc_o,
  output logic [DATA_W-1:0]     opnd_o
);

  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] diff;
  logic              ge;

  always_comb begin
    addend = opnd_i[0] ? b_i : '0;
    sum    = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + {1'b0, addend};
    rem_sh = {acc_i[2*DATA_W-1:DATA_W], opnd_i[DATA_W-1]};
    // Explicit compare so a zero divisor always subtracts (quotient all ones).
    ge     = (rem_sh >= {1'b0, b_i});
    diff   = rem_sh[DATA_W-1:0] - b_i;

    if (is_div_i) begin
      acc_o  = ge ? {diff, acc_i[DATA_W-2:0], 1'b1}
                  : {rem_sh[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b0};
      opnd_o = opnd_i << 1;
    end else begin
      acc_o  = {sum, acc_i[DATA_W-1:1]};
      opnd_o = opnd_i >> 1;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 33-edge fixed latency.
// Optional MDU_EARLY_TERM_EN: multiplies finish once remaining multiplier bits are zero.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W,
  parameter int CNT_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;

  logic [2*DATA_W-1:0] step_acc;
  logic [DATA_W-1:0]   step_opnd;
  logic                signed_op, is_div_op;
  logic [DATA_W-1:0]   rs_mag, rt_mag;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  mdu_step #(.DATA_W(DATA_W)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .b_i      (b_q),
    .acc_o    (step_acc),
    .opnd_o   (step_opnd)
  );

  always_comb begin
    signed_op = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    is_div_op = (op_i == MDU_DIV)  || (op_i == MDU_DIVU);
    rs_mag    = (signed_op && rs_i[DATA_W-1]) ? (~rs_i + 1'b1) : rs_i;
    rt_mag    = (signed_op && rt_i[DATA_W-1]) ? (~rt_i + 1'b1) : rt_i;
    prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix   = neg_res_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];
    rem_fix   = neg_rem_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1)
                          : acc_q[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i) begin
          is_div_d  = is_div_op;
          opnd_d    = is_div_op ? rs_mag : rt_mag;
          b_d       = is_div_op ? rt_mag : rs_mag;
          // Zero divisor skips quotient negation; remainder fixup restores rs_i.
          neg_res_d = signed_op && (rs_i[DATA_W-1] ^ rt_i[DATA_W-1]) &&
                      (!is_div_op || (rt_i != '0));
          neg_rem_d = signed_op && is_div_op && rs_i[DATA_W-1];
          acc_d     = '0;
          cnt_d     = CNT_W'(DATA_W - 1);
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        acc_d  = step_acc;
        opnd_d = step_opnd;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
`ifdef MDU_EARLY_TERM_EN
        // Remaining zero-bit iterations are pure right shifts; apply them at once.
        if (!is_div_q && (step_opnd == '0)) begin
          acc_d   = step_acc >> cnt_q;
          state_d = S_FIX;
        end
`endif
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: multiply/divide results, latency, MT writes, reset abort.
module tb_mdu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs_i, rt_i, wdata_i;
  logic        hi_we_i, lo_we_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  mdu_ctrl dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .hi_we_i (hi_we_i),
    .lo_we_i (lo_we_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one op, wait (bounded) for done_o, then check latency, busy and HI/LO.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat);
    int lat;
    logic busy_drop;
    lat = 0;
    busy_drop = 1'b0;
    op_i = op; rs_i = rs; rt_i = rt; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (!done_o && lat < 100) begin
      if (!busy_o) busy_drop = 1'b1;
      tick();
      lat++;
    end
    chk({tag, "_done"}, 64'(done_o), 64'd1);
    chk({tag, "_busy_held"}, 64'(busy_drop), 64'd0);
    if (exp_lat >= 0) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_end"}, 64'(busy_o), 64'd0);
    chk({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
    tick();
    chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int lat_early;
    logic saw_done;
`ifdef MDU_EARLY_TERM_EN
    lat_early = 2;
`else
    lat_early = 33;
`endif
    rst_i = 1'b0; start_i = 1'b0; op_i = 2'b00; rs_i = '0; rt_i = '0;
    hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
    #12;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    rst_i = 1'b1;
    tick();

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 33);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33);
    run_op("mult_both_neg", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33);
    run_op("multu_early", 2'b01, 32'd5, 32'd1, 32'd0, 32'd5, lat_early);

    // MTHI while idle
    hi_we_i = 1'b1; wdata_i = 32'h1234_5678;
    tick();
    hi_we_i = 1'b0;
    chk("mthi_idle", 64'(hi_o), 64'h1234_5678);

    // MULTU with ignored MTLO and a second start mid-run
    op_i = 2'b01; rs_i = 32'd3; rt_i = 32'h8000_0001; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    lo_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    start_i = 1'b1; op_i = 2'b11; rs_i = 32'd1; rt_i = 32'd1;
    tick();
    lo_we_i = 1'b0; start_i = 1'b0;
    chk("mtlo_busy_ignored", 64'(lo_o), 64'd5);
    chk("hi_stable_run", 64'(hi_o), 64'h1234_5678);
    chk("busy_mid_run", 64'(busy_o), 64'd1);
    for (int i = 0; i < 100 && !done_o; i++) tick();
    chk("busy_op_done", 64'(done_o), 64'd1);
    chk("busy_op_hi", 64'(hi_o), 64'h0000_0001);
    chk("busy_op_lo", 64'(lo_o), 64'h8000_0003);
    tick();
    chk("busy_op_no_restart", 64'(busy_o), 64'd0);

    // Reset asserted at E10 of a DIVU
    op_i = 2'b11; rs_i = 32'd1000; rt_i = 32'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    @(posedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_hi", 64'(hi_o), 64'd0);
    chk("abort_lo", 64'(lo_o), 64'd0);
    tick();
    rst_i = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    run_op("multu_after_rst", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Iterative multiply/divide unit controller for the pipeline CPU's EX stage.
- Sequences MULT/MULTU/DIV/DIVU over 32 iteration cycles and owns the HI/LO registers.
- Supports MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.
- Asserts busy so the hazard unit stalls dependent instructions.

Parameters:
- DATA_W, 32: operand/HI/LO width; iteration count equals DATA_W.
- CNT_W, 5: iteration counter width, equal to clog2(DATA_W).

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  launch operation; sampled only when busy_o=0.
- op_i  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (equals funct[1:0] of 0x18–0x1B).
- rs_i  input  DATA_W  multiplicand / dividend.
- rt_i  input  DATA_W  multiplier / divisor.
- hi_we_i  input  1  MTHI write enable.
- lo_we_i  input  1  MTLO write enable.
- wdata_i  input  DATA_W  MTHI/MTLO data.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse: HI/LO just updated by an operation.
- hi_o  output  DATA_W  HI register.
- lo_o  output  DATA_W  LO register.

Behaviour:
- Reset (rst_i=0, asynchronous, may occur mid-operation):
  - state=IDLE; counter, working registers, hi_o, lo_o = 0; busy_o=0; done_o=0.
  - An in-flight operation is discarded and produces no done_o.
- States: IDLE, RUN, FIX. busy_o = (state != IDLE), decoded from the state register.
- IDLE, start_i=1 (edge E0):
  - Latch op_i.
  - For signed ops, latch operand magnitudes, sign of result (rs^rt) and sign of dividend; unsigned ops use operands as-is.
  - Clear the 64-bit accumulator / partial remainder; counter=DATA_W-1; go to RUN.
- RUN, one iteration per edge:
  - MUL: shift-add, one multiplier bit per edge, LSB first.
  - DIV: restoring division, one quotient bit per edge, MSB first.
  - counter decrements each edge; when counter==0, go to FIX at that edge.
  - RUN lasts exactly DATA_W edges (E1..E32).
- FIX (edge E33):
  - Apply sign correction.
    - MULT: negate the 64-bit product if result sign is set.
    - DIV: negate the quotient if result sign is set; remainder takes the dividend's sign.
  - Write HI/LO. MUL: HI=product[63:32], LO=product[31:0]. DIV: LO=quotient, HI=remainder.
  - Return to IDLE. done_o is registered, high for the single cycle after E33.
  - Fixed latency: start edge to HI/LO valid = 33 edges.
- Divide by zero, any DIV/DIVU with rt_i=0:
  - LO=0xFFFFFFFF, HI=rs_i (original value). No sign fixup, no exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural wrap, no trap).
- start_i while busy_o=1: ignored; the hazard unit is required to hold the instruction.
- hi_we_i/lo_we_i:
  - Honoured only when busy_o=0; ignored while busy.
  - Same edge as an accepted start: the write is applied and the later result overwrites it.
- hi_o/lo_o are stable during RUN (previous values) and change only at FIX or an MT write.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined: in RUN for MULT/MULTU, if all remaining unprocessed multiplier bits are zero, go to FIX on that edge.
  - Latency becomes variable, minimum 2 edges (rt_i=0: E1 RUN-to-FIX, E2 FIX).
  - DIV is unaffected.
- Undefined: fixed 33-edge latency for all ops.

Decomposition:
- Package mdu_pkg:
  - op encodings MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11;
  - state encoding IDLE/RUN/FIX;
  - DATA_W default.
- One combinational sub-module mdu_step: a single shift-add or restore-subtract iteration on {accumulator, operand}, selected by an is_div input.
- Counter, FSM and HI/LO registers stay in mdu_ctrl.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy_o high E0–E33; done_o one cycle; HI=0xFFFFFFFE, LO=0x00000001 (fixed latency build).
- MULT rs=0xFFFFFFFD (-3) rt=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV rs=0xFFFFFFF9 (-7) rt=0x00000002 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); then DIVU rs=100 rt=0 -> LO=0xFFFFFFFF, HI=0x00000064.
- MTHI 0x12345678 while idle -> hi_o=0x12345678 next cycle; during a MULTU: MTLO 0xDEADBEEF and a second start_i are both ignored, and the original result lands.
- Reset low at edge E10 of a DIVU -> busy_o=0 and hi_o/lo_o=0 immediately; no done_o; a subsequent MULTU 6*7 yields LO=42, HI=0.
- With MDU_EARLY_TERM_EN: MULTU rs=5 rt=1 -> done_o 2 edges after start, LO=5; without the macro, 33 edges.
